// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port arbiter in front of a single fixed-latency data memory.
//
// Port 0 (datapath) and port 1 (loader/debug) issue word accesses. One access
// is in flight at a time. A three-state FSM (IDLE -> ACCESS -> DONE) grants a
// winner, drives the memory for MEM_LATENCY cycles, returns read data and
// spends one DONE cycle before sampling requests again.
//
// Parameters:
//   ADDR_WIDTH  word address width (default 16)
//   DATA_WIDTH  data word width (default 16)
//   MEM_LATENCY memory access cycles, 1..15 (default 2)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req*/we*/addr*/wdata*       request, write flag, address and data per port
//   gnt*/done*                  one-cycle accept / completion pulses per port
//   rdata*                      per-port read data, held until the next read
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
//   busy                        high whenever the FSM is not IDLE
//
// Configuration macro DMEM_ARB_RR_EN: when defined, simultaneous requests are
// won by the port that did not win last (round robin, port 0 first after
// reset); when undefined, port 0 always wins (fixed priority).

module dmem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter runs from MEM_LATENCY-1 down to 0, so the access spans exactly
  // MEM_LATENCY cycles with mem_rdata sampled in the last one.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_q, owner_d;   // 0 = port 0 owns the access
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  win;
`ifdef DMEM_ARB_RR_EN
  logic                  last_grant_q, last_grant_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    win         = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
`ifdef DMEM_ARB_RR_EN
          win          = (req0 && req1) ? ~last_grant_q : req1;
          last_grant_d = win;
`else
          win          = ~req0;
`endif
          owner_d     = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          mem_en_d    = 1'b1;
          mem_we_d    = win ? we1 : we0;
          mem_addr_d  = win ? addr1 : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Writes leave the requester's rdata untouched.
          if (!mem_we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = DONE;
        end
      end

      // Requests are deliberately not sampled here; this enforces the
      // MEM_LATENCY+2 request spacing.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- self-checking bench for dmem_arbiter.
// u_dut uses MEM_LATENCY=2 with a small memory model; u_dut1 uses
// MEM_LATENCY=1 with address-derived read data. Expected read data is queued
// when a request is issued and compared when the matching done appears.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          check_cnt = 0;
  int          fail_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with MEM_LATENCY = 2 ----------------
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: unwritten words read a fixed pattern, 0x0010 holds 0xBEEF.
  logic [15:0] tb_mem [256];
  bit          wr_valid [256];

  function automatic logic [15:0] base_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hC0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      tb_mem[mem_addr[7:0]]   <= mem_wdata;
      wr_valid[mem_addr[7:0]] <= 1'b1;
    end
  end

  assign mem_rdata = wr_valid[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : base_val(mem_addr[7:0]);

  // ---------------- DUT with MEM_LATENCY = 1 ----------------
  logic        req0_b, req1_b, we0_b, we1_b;
  logic [15:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic        gnt0_b, gnt1_b, done0_b, done1_b, mem_en_b, mem_we_b, busy_b;
  logic [15:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  assign mem_rdata_b = mem_addr_b ^ 16'h5A5A;

  // ---------------- scoreboard and bench model ----------------
  typedef struct {
    logic        port;
    logic [15:0] data;
  } sb_t;

  sb_t         sb[$];
  sb_t         sb1[$];
  logic [15:0] exp_rd [2];
  logic        exp_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected completion record for u_dut; writes expect rdata to stay put.
  task automatic push_exp(input logic port, input logic we, input logic [15:0] data);
    sb_t e;
    if (!we) exp_rd[port] = data;
    e.port = port;
    e.data = exp_rd[port];
    sb.push_back(e);
  endtask

  // Completion monitor for u_dut.
  always @(negedge clk) begin
    if (gnt0 || gnt1) check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", {30'd0, done1, done0}, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        check("done_port", {31'd0, done1}, {31'd0, e.port});
        check("rdata", {16'd0, e.port ? rdata1 : rdata0}, {16'd0, e.data});
        check("rdata_other", {16'd0, e.port ? rdata0 : rdata1}, {16'd0, exp_rd[~e.port]});
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = req; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  // One isolated access on u_dut (IDLE at call, called on a negedge).
  task automatic single(input logic port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_data);
    drive(port, 1'b1, we, addr, wdata);
    push_exp(port, we, exp_data);
    @(negedge clk);  // cycle 1: grant
    check("gnt_win",  {31'd0, port ? gnt1 : gnt0}, 32'd1);
    check("gnt_lose", {31'd0, port ? gnt0 : gnt1}, 32'd0);
    check("en_c1",    {31'd0, mem_en}, 32'd1);
    check("we_c1",    {31'd0, mem_we}, {31'd0, we});
    check("addr_c1",  {16'd0, mem_addr}, {16'd0, addr});
    if (we) check("wdata_c1", {16'd0, mem_wdata}, {16'd0, wdata});
    check("busy_c1",  {31'd0, busy}, 32'd1);
    // Requester may drop and scramble its inputs once granted.
    drive(port, 1'b0, ~we, ~addr, ~wdata);
    @(negedge clk);  // cycle 2: access continues
    check("gnt_pulse", {30'd0, gnt1, gnt0}, 32'd0);
    check("en_c2",     {31'd0, mem_en}, 32'd1);
    check("we_c2",     {31'd0, mem_we}, {31'd0, we});
    check("addr_c2",   {16'd0, mem_addr}, {16'd0, addr});
    if (we) check("wdata_c2", {16'd0, mem_wdata}, {16'd0, wdata});
    check("done_early", {30'd0, done1, done0}, 32'd0);
    @(negedge clk);  // cycle 3: done
    check("done_c3", {31'd0, port ? done1 : done0}, 32'd1);
    check("en_c3",   {31'd0, mem_en}, 32'd0);
    check("we_c3",   {31'd0, mem_we}, 32'd0);
    check("busy_c3", {31'd0, busy}, 32'd1);
    @(negedge clk);  // cycle 4: idle
    check("busy_c4", {31'd0, busy}, 32'd0);
    check("done_c4", {30'd0, done1, done0}, 32'd0);
    exp_last = port;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   n_gnt;
    int   prev;
    int   n_done;
    logic w;
    logic exp_w;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    req0_b = 1'b0; req1_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
    addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_last = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
    check("rst_mem",    {30'd0, mem_en, mem_we}, 32'd0);
    check("rst_addr",   {16'd0, mem_addr}, 32'd0);
    check("rst_wdata",  {16'd0, mem_wdata}, 32'd0);
    check("rst_rdata",  {rdata1, rdata0}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);

    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_quiet", {27'd0, gnt0, gnt1, done0, done1, mem_en}, 32'd0);
    end

    // Both ports request continuously.
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    n_gnt = 0;
    prev  = 0;
    for (int i = 0; i < 40 && n_gnt < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        w = gnt1;
`ifdef DMEM_ARB_RR_EN
        exp_w = ~exp_last;
`else
        exp_w = 1'b0;
`endif
        check("cont_winner", {31'd0, w}, {31'd0, exp_w});
        if (n_gnt > 0) check("cont_spacing", cyc - prev, 4);
        push_exp(w, 1'b0, 16'hBEEF);
        exp_last = w;
        prev = cyc;
        n_gnt++;
        if (n_gnt == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    if (n_gnt < 4) check("cont_timeout", n_gnt, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle("cont_idle_timeout");
    @(negedge clk);

    // Directed single accesses.
    single(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    single(1'b1, 1'b1, 16'h0004, 16'h1234, 16'h0000);
    single(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234);
    single(1'b0, 1'b1, 16'h0021, 16'hA5C3, 16'h0000);
    single(1'b0, 1'b0, 16'h0021, 16'h0000, 16'hA5C3);
    single(1'b1, 1'b0, 16'h0030, 16'h0000, 16'hC030);

    // Reset during ACCESS aborts the access.
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    check("abort_gnt", {31'd0, gnt0}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("abort_en_before", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_en",    {31'd0, mem_en}, 32'd0);
    check("abort_we",    {31'd0, mem_we}, 32'd0);
    check("abort_done",  {30'd0, done1, done0}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_rdata", {rdata1, rdata0}, 32'd0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_last  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", {30'd0, done1, done0}, 32'd0);
    single(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    check("sb_empty", sb.size(), 0);

    // MEM_LATENCY = 1: back-to-back reads on port 0.
    req0_b  = 1'b1;
    addr0_b = 16'h0020;
    n_gnt  = 0;
    n_done = 0;
    prev   = 0;
    for (int i = 0; i < 30 && n_done < 3; i++) begin
      @(negedge clk);
      check("l1_gnt1", {30'd0, gnt1_b, done1_b}, 32'd0);
      if (gnt0_b) begin
        sb_t e;
        if (n_gnt > 0) check("l1_spacing", cyc - prev, 3);
        check("l1_en", {30'd0, mem_en_b, mem_we_b}, 32'd2);
        check("l1_wdata", {16'd0, mem_wdata_b}, 32'd0);
        e.port = 1'b0;
        e.data = 16'h0020 ^ 16'h5A5A;
        sb1.push_back(e);
        prev = cyc;
        n_gnt++;
      end
      if (done0_b) begin
        check("l1_done_gap", cyc - prev, 1);
        if (sb1.size() != 0) begin
          sb_t e;
          e = sb1.pop_front();
          check("l1_rdata", {16'd0, rdata0_b}, {16'd0, e.data});
        end else begin
          check("l1_done_unexpected", {31'd0, done0_b}, 32'd0);
        end
        n_done++;
      end
    end
    req0_b = 1'b0;
    if (n_done < 3) check("l1_timeout", n_done, 3);
    repeat (3) @(negedge clk);
    check("l1_idle", {29'd0, busy_b, gnt0_b, mem_en_b}, 32'd0);
    check("l1_rdata1", {16'd0, rdata1_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_WIDTH, default 16, word address width; DATA_WIDTH, default 16, data word width; MEM_LATENCY, default 2, memory access cycles (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0 / req1  input  1  access request from port 0 (datapath) / port 1 (loader/debug).
REQ-005 we0 / we1  input  1  1 = write, 0 = read.
REQ-006 addr0 / addr1  input  ADDR_WIDTH  word address.
REQ-007 wdata0 / wdata1  input  DATA_WIDTH  write data.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse when the request is accepted.
REQ-009 done0 / done1  output  1  one-cycle pulse when the access completes.
REQ-010 rdata0 / rdata1  output  DATA_WIDTH  read data; valid while the matching done is high after a read.
REQ-011 mem_en  output  1  memory access enable.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address.
REQ-014 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-015 mem_rdata  input  DATA_WIDTH  memory read data; valid on the final cycle of an access.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 IDLE SHALL transition on a posedge with req0|req1 high as follows: latch the winner and its we/addr/wdata into mem_we/mem_addr/mem_wdata; set mem_en=1; pulse gnt of the winner; load cnt=MEM_LATENCY-1; go to ACCESS.
REQ-019 ACCESS SHALL hold mem_en, mem_we, mem_addr and mem_wdata constant; if cnt!=0 it SHALL decrement cnt; if cnt==0 it SHALL capture mem_rdata into the winner's rdata (reads only), set mem_en=0 and mem_we=0, pulse the winner's done, and go to DONE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; a new request SHALL NOT be sampled in DONE.
REQ-021 Latency SHALL be: req sampled at edge E, gnt high in cycle E+1, done high in cycle E+1+MEM_LATENCY; minimum request-to-request spacing is MEM_LATENCY+2 cycles.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until its gnt; it may drop them afterwards; req still high after its done SHALL count as a new request.
REQ-023 The non-winning requester's req SHALL remain pending and SHALL be arbitrated on the next IDLE cycle.
REQ-024 rdata of a port SHALL hold its last value until that port's next read completes; writes SHALL NOT modify rdata.
REQ-025 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together; at most one access SHALL be in flight.
REQ-026 With no request in IDLE, all pulse outputs and mem_en SHALL stay 0.

Reset
REQ-027 When rst_n=0 at a posedge, the block SHALL set state=IDLE, cnt=0, gnt*/done*/mem_en/mem_we/busy=0, mem_addr/mem_wdata/rdata*=0 and last_grant=1.
REQ-028 Reset during ACCESS SHALL abort the access: mem_en and mem_we SHALL be 0 from the next cycle, and no done SHALL be issued for the aborted access.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be won by the port that did not win last (last_grant register, updated on every gnt), so port 0 wins first after reset.
REQ-030 With DMEM_ARB_RR_EN undefined, port 0 SHALL always win simultaneous requests (fixed priority) and last_grant SHALL be absent.

Verification
REQ-031 MEM_LATENCY=2; req0 read addr 0x0010 with mem_rdata=0xBEEF -> gnt0 at cycle 1, mem_en high in cycles 1-2, done0 at cycle 3 with rdata0=0xBEEF.
REQ-032 req1 write addr 0x0004 data 0x1234 -> mem_we=1, mem_addr=0x0004, mem_wdata=0x1234 held for 2 cycles; done1 pulses; rdata1 unchanged.
REQ-033 req0 and req1 held high continuously with DMEM_ARB_RR_EN defined -> grants alternate 0,1,0,1 with gnt spacing of 4 cycles; with DMEM_ARB_RR_EN undefined -> only gnt0.
REQ-034 rst_n driven low in the cycle after gnt0 -> mem_en=0 the next cycle, no done0, busy=0; a subsequent req1 is served normally.
REQ-035 MEM_LATENCY=1, back-to-back req0 reads -> gnt0 every 3 cycles, done0 exactly 1 cycle after each gnt0.
